// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control,
// memory handshakes and the architectural PC.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  input  logic [31:0] npc_op1,
  input  logic [31:0] npc_op2,
  input  logic        take_branch,
  input  logic        is_jalr,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        writes_rd,
  input  logic        illegal_inst,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_issued;
  logic        r_store;
  logic        r_wrd;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_npc;
  logic [31:0] w_sum;
  logic [31:0] w_target;
  logic        w_misal;
  logic        w_fire;

  // Once a fetch is issued it must stay up until acked, regardless of stall.
  assign imem_req  = (r_state == S_FETCH) && (r_issued || !stall);
  assign w_fire    = imem_req && imem_ack;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign inst      = r_inst;
  assign dmem_req  = (r_state == S_MEM);
  assign dmem_we   = dmem_req && r_store;
  assign rf_we     = (r_state == S_WB) && r_wrd;
  assign halted    = (r_state == S_HALT);

  always_comb begin
    w_sum = npc_op1 + npc_op2;
    if (is_jalr)
      w_sum[0] = 1'b0;
    w_target = take_branch ? w_sum : r_pc + 32'd4;
    w_misal  = |w_target[1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  if (w_fire) w_next = S_DECODE;
      S_DECODE: w_next = illegal_inst ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (w_misal)
          w_next = S_HALT;
        else if (is_load || is_store)
          w_next = S_MEM;
        else
          w_next = S_WB;
      end
      S_MEM:    if (dmem_ack) w_next = S_WB;
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issued <= 1'b0;
      r_pc     <= RESET_PC;
      r_inst   <= '0;
      r_npc    <= '0;
      r_store  <= 1'b0;
      r_wrd    <= 1'b0;
    end else begin
      if (r_state == S_FETCH) begin
        if (w_fire) begin
          r_inst   <= imem_rdata;
          r_issued <= 1'b0;
        end else if (imem_req) begin
          r_issued <= 1'b1;
        end
      end
      if (r_state == S_EXEC && !w_misal) begin
        r_npc   <= w_target;
        r_store <= is_store;
        r_wrd   <= writes_rd;
      end
      if (r_state == S_WB)
        r_pc <= r_npc;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised self-checking bench for pc_sequencer; the bench acts as both
// memories and predicts PC, strobes and latency per instruction.
module tb_pc_sequencer;

  logic        clk = 0;
  logic        rst = 0;
  logic        stall = 0;
  logic        imem_ack = 0;
  logic [31:0] imem_rdata = 0;
  logic [31:0] npc_op1 = 0;
  logic [31:0] npc_op2 = 0;
  logic        take_branch = 0;
  logic        is_jalr = 0;
  logic        is_load = 0;
  logic        is_store = 0;
  logic        writes_rd = 0;
  logic        illegal_inst = 0;
  logic        dmem_ack = 0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] inst;
  logic        dmem_req;
  logic        dmem_we;
  logic        rf_we;
  logic [31:0] pc;
  logic        halted;

  pc_sequencer #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .npc_op1(npc_op1), .npc_op2(npc_op2),
    .take_branch(take_branch), .is_jalr(is_jalr),
    .is_load(is_load), .is_store(is_store),
    .writes_rd(writes_rd), .illegal_inst(illegal_inst),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .rf_we(rf_we),
    .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  logic [31:0] m_pc;

  typedef struct {
    logic [31:0] rdata, op1, op2;
    bit take, jalr, load, store, wrd, ill, spost;
    int idly, ddly, spre;
  } instr_t;

  typedef struct {
    int pre_req, rf, dreq, dwe, pc_bad, addr_bad;
    logic [31:0] pc, inst;
    logic req, hlt;
  } obs_t;

  function automatic instr_t mk(input logic [31:0] a, input logic [31:0] b,
                                input bit tk, input bit jr, input bit ld,
                                input bit st, input bit wr);
    instr_t t;
    t.rdata = $urandom;
    t.op1 = a; t.op2 = b; t.take = tk; t.jalr = jr;
    t.load = ld; t.store = st; t.wrd = wr;
    t.ill = 0; t.spost = 0; t.idly = 0; t.ddly = 0; t.spre = 0;
    return t;
  endfunction

  // Reference: next PC from the operand rules, independent of FSM structure.
  function automatic logic [31:0] ref_target(input logic [31:0] p,
                                             input instr_t t);
    logic [31:0] s;
    s = t.op1 + t.op2;
    if (t.jalr) s = s & ~32'd1;
    return t.take ? s : p + 32'd4;
  endfunction

  function automatic bit ref_halt(input logic [31:0] p, input instr_t t);
    return t.ill || (ref_target(p, t) % 4 != 0);
  endfunction

  // Cycles from the first FETCH cycle until the next FETCH (or HALT).
  function automatic int ref_cycles(input logic [31:0] p, input instr_t t);
    int n;
    n = t.spre + t.idly + 2;
    if (t.ill) return n;
    n += 1;
    if (ref_halt(p, t)) return n;
    if (t.load || t.store) n += t.ddly + 1;
    return n + 1;
  endfunction

  task automatic drive(input instr_t t, input logic [31:0] p,
                       input int ncyc, output obs_t o);
    int ireq;
    o = '{default: 0};
    ireq = 0;
    npc_op1 = t.op1; npc_op2 = t.op2;
    take_branch = t.take; is_jalr = t.jalr;
    is_load = t.load; is_store = t.store;
    writes_rd = t.wrd; illegal_inst = t.ill;
    for (int k = 0; k < ncyc; k++) begin
      stall = (k < t.spre) ? 1'b1 : (ireq > 0 ? t.spost : 1'b0);
      #1;
      if (k < t.spre) begin
        if (imem_req) o.pre_req++;
        imem_ack = 1'b1;
        imem_rdata = $urandom;
      end else if (imem_req) begin
        imem_ack = (ireq == t.idly);
        imem_rdata = imem_ack ? t.rdata : $urandom;
        ireq++;
      end else begin
        imem_ack = 1'b0;
      end
      if (dmem_req) begin
        dmem_ack = (o.dreq == t.ddly);
        o.dreq++;
        if (dmem_we) o.dwe++;
      end else begin
        dmem_ack = 1'b0;
      end
      if (rf_we) o.rf++;
      if (pc !== p) o.pc_bad++;
      if (imem_addr !== pc) o.addr_bad++;
      @(negedge clk);
    end
    stall = 0; imem_ack = 0; dmem_ack = 0;
    #1;
    o.pc = pc; o.inst = inst; o.req = imem_req; o.hlt = halted;
  endtask

  task automatic do_reset();
    stall = 0; imem_ack = 0; dmem_ack = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    #1;
    m_pc = 32'h0;
  endtask

  task automatic test_reset();
    instr_t t;
    obs_t o;
    #1 rst = 1;
    #2;
    n_tot++; if (pc !== 32'h0) $display("FAIL rst_pc got %h want 0", pc); else n_pass++;
    n_tot++; if (inst !== 32'h0) $display("FAIL rst_inst got %h want 0", inst); else n_pass++;
    n_tot++;
    if ({imem_req, dmem_req, dmem_we, rf_we, halted} !== 5'b0)
      $display("FAIL rst_strobes got %b want 00000",
               {imem_req, dmem_req, dmem_we, rf_we, halted});
    else n_pass++;
    @(negedge clk); @(negedge clk);
    rst = 0;
    #1;
    n_tot++; if (imem_req !== 1'b0) $display("FAIL idle_req got %b want 0", imem_req); else n_pass++;
    @(negedge clk); #1;
    n_tot++; if (imem_req !== 1'b1) $display("FAIL fetch_req got %b want 1", imem_req); else n_pass++;
    m_pc = 32'h0;
    t = mk(32'h0, 32'h4, 0, 0, 0, 0, 1);
    drive(t, m_pc, 4, o);
    n_tot++; if (o.pc !== 32'h4) $display("FAIL alu_pc got %h want 4", o.pc); else n_pass++;
    n_tot++; if (o.rf !== 1) $display("FAIL alu_rf got %0d want 1", o.rf); else n_pass++;
    n_tot++; if (o.req !== 1'b1) $display("FAIL alu_refetch got %b want 1", o.req); else n_pass++;
    n_tot++; if (o.inst !== t.rdata) $display("FAIL alu_inst got %h want %h", o.inst, t.rdata); else n_pass++;
    m_pc = 32'h4;
  endtask

  task automatic test_branch();
    instr_t t;
    obs_t o;
    logic [31:0] want [4];
    instr_t seq [4];
    seq[0] = mk(32'h0FC, 32'h4, 1, 0, 0, 0, 0);
    seq[1] = mk(32'h100, 32'hFFFF_FFF0, 1, 0, 0, 0, 0);
    seq[2] = mk(32'h080, 32'h080, 1, 0, 0, 0, 0);
    seq[3] = mk(32'h100, 32'hFFFF_FFF0, 0, 0, 0, 0, 0);
    want[0] = 32'h100; want[1] = 32'h0F0; want[2] = 32'h100; want[3] = 32'h104;
    for (int i = 0; i < 4; i++) begin
      t = seq[i];
      drive(t, m_pc, ref_cycles(m_pc, t), o);
      n_tot++; if (o.pc !== want[i]) $display("FAIL br%0d_pc got %h want %h", i, o.pc, want[i]); else n_pass++;
      n_tot++; if (o.rf !== 0) $display("FAIL br%0d_rf got %0d want 0", i, o.rf); else n_pass++;
      m_pc = want[i];
    end
  endtask

  task automatic test_jalr();
    instr_t t;
    obs_t o;
    t = mk(32'h201, 32'h3, 1, 1, 0, 0, 1);
    drive(t, m_pc, ref_cycles(m_pc, t), o);
    n_tot++; if (o.pc !== 32'h204) $display("FAIL jalr_pc got %h want 204", o.pc); else n_pass++;
    n_tot++; if (o.rf !== 1) $display("FAIL jalr_rf got %0d want 1", o.rf); else n_pass++;
    m_pc = 32'h204;
    t = mk(32'h203, 32'h0, 1, 1, 0, 0, 1);
    drive(t, m_pc, ref_cycles(m_pc, t), o);
    n_tot++; if (o.hlt !== 1'b1) $display("FAIL jalr_mis_halt got %b want 1", o.hlt); else n_pass++;
    n_tot++; if (o.pc !== 32'h204) $display("FAIL jalr_mis_pc got %h want 204", o.pc); else n_pass++;
    n_tot++; if (o.rf !== 0) $display("FAIL jalr_mis_rf got %0d want 0", o.rf); else n_pass++;
    do_reset();
  endtask

  task automatic test_mem();
    instr_t t;
    obs_t o;
    t = mk(32'h0, 32'h0, 0, 0, 1, 0, 1);
    t.ddly = 3;
    drive(t, m_pc, 8, o);
    n_tot++; if (o.dreq !== 4) $display("FAIL ld_dreq got %0d want 4", o.dreq); else n_pass++;
    n_tot++; if (o.dwe !== 0) $display("FAIL ld_we got %0d want 0", o.dwe); else n_pass++;
    n_tot++; if (o.rf !== 1) $display("FAIL ld_rf got %0d want 1", o.rf); else n_pass++;
    n_tot++; if (o.pc !== 32'h4 || o.req !== 1'b1)
      $display("FAIL ld_lat got pc=%h req=%b want pc=4 req=1", o.pc, o.req);
    else n_pass++;
    t = mk(32'h0, 32'h0, 0, 0, 0, 1, 0);
    drive(t, 32'h4, 5, o);
    n_tot++; if (o.dwe !== 1) $display("FAIL st_we got %0d want 1", o.dwe); else n_pass++;
    n_tot++; if (o.rf !== 0) $display("FAIL st_rf got %0d want 0", o.rf); else n_pass++;
    n_tot++; if (o.pc !== 32'h8) $display("FAIL st_pc got %h want 8", o.pc); else n_pass++;
    m_pc = 32'h8;
  endtask

  task automatic test_stall();
    instr_t t;
    obs_t o;
    t = mk(32'h0, 32'h0, 0, 0, 0, 0, 1);
    t.spre = 3; t.idly = 2; t.spost = 1;
    drive(t, m_pc, ref_cycles(m_pc, t), o);
    n_tot++; if (o.pre_req !== 0) $display("FAIL stall_pre_req got %0d want 0", o.pre_req); else n_pass++;
    n_tot++; if (o.inst !== t.rdata) $display("FAIL stall_inst got %h want %h", o.inst, t.rdata); else n_pass++;
    n_tot++; if (o.pc !== m_pc + 32'd4 || o.req !== 1'b1)
      $display("FAIL stall_lat got pc=%h req=%b want pc=%h req=1", o.pc, o.req, m_pc + 32'd4);
    else n_pass++;
    m_pc = m_pc + 32'd4;
  endtask

  task automatic test_illegal();
    instr_t t;
    obs_t o;
    int bad;
    t = mk(32'h0, 32'h4, 1, 0, 1, 0, 1);
    t.ill = 1;
    drive(t, m_pc, ref_cycles(m_pc, t), o);
    n_tot++; if (o.hlt !== 1'b1) $display("FAIL ill_halt got %b want 1", o.hlt); else n_pass++;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      stall = 1'($urandom); imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
      #1;
      if ({imem_req, dmem_req, dmem_we, rf_we} !== 4'b0 || halted !== 1'b1 || pc !== m_pc)
        bad++;
      @(negedge clk);
    end
    n_tot++; if (bad !== 0) $display("FAIL ill_hold got %0d bad cycles want 0", bad); else n_pass++;
    do_reset();
  endtask

  task automatic test_rst_mid();
    instr_t t;
    obs_t o;
    t = mk(32'h0, 32'h0, 0, 0, 1, 0, 1);
    t.ddly = 10;
    drive(t, m_pc, 5, o);
    n_tot++; if (dmem_req !== 1'b1) $display("FAIL mid_dreq got %b want 1", dmem_req); else n_pass++;
    #1 rst = 1;
    #1;
    n_tot++; if (dmem_req !== 1'b0 || pc !== 32'h0)
      $display("FAIL mid_async got dreq=%b pc=%h want 0 0", dmem_req, pc);
    else n_pass++;
    @(negedge clk);
    rst = 0;
    #1;
    n_tot++; if (imem_req !== 1'b0) $display("FAIL mid_idle got %b want 0", imem_req); else n_pass++;
    @(negedge clk); #1;
    m_pc = 32'h0;
    t = mk(32'h0, 32'h0, 0, 0, 0, 0, 1);
    drive(t, m_pc, 4, o);
    n_tot++; if (o.pc !== 32'h4) $display("FAIL mid_restart got %h want 4", o.pc); else n_pass++;
    m_pc = 32'h4;
  endtask

  task automatic test_random();
    instr_t t;
    obs_t o;
    bit h, mem;
    logic [31:0] tg, e_pc;
    int e_rf, e_dr, e_dw, r;
    for (int i = 0; i < 40; i++) begin
      t = mk($urandom & ~32'd3, $urandom & ~32'd3, 1'($urandom), 1'($urandom % 4 == 0), 0, 0, 0);
      if ($urandom % 8 == 0) t.op1 = t.op1 | ($urandom % 4);
      r = $urandom % 4;
      t.load = (r == 0); t.store = (r == 1);
      t.wrd = !t.store && 1'($urandom);
      t.ill = ($urandom % 16 == 0);
      t.idly = $urandom % 4; t.ddly = $urandom % 4;
      t.spre = $urandom % 3; t.spost = 1'($urandom);
      h = ref_halt(m_pc, t);
      tg = ref_target(m_pc, t);
      mem = !h && (t.load || t.store);
      e_pc = h ? m_pc : tg;
      e_rf = (!h && t.wrd) ? 1 : 0;
      e_dr = mem ? t.ddly + 1 : 0;
      e_dw = (mem && t.store) ? t.ddly + 1 : 0;
      drive(t, m_pc, ref_cycles(m_pc, t), o);
      n_tot++; if (o.hlt !== h) $display("FAIL rnd%0d_halt got %b want %b", i, o.hlt, h); else n_pass++;
      n_tot++; if (o.pc !== e_pc) $display("FAIL rnd%0d_pc got %h want %h", i, o.pc, e_pc); else n_pass++;
      n_tot++; if (o.req !== !h) $display("FAIL rnd%0d_req got %b want %b", i, o.req, !h); else n_pass++;
      n_tot++; if (o.rf !== e_rf) $display("FAIL rnd%0d_rf got %0d want %0d", i, o.rf, e_rf); else n_pass++;
      n_tot++; if (o.dreq !== e_dr) $display("FAIL rnd%0d_dreq got %0d want %0d", i, o.dreq, e_dr); else n_pass++;
      n_tot++; if (o.dwe !== e_dw) $display("FAIL rnd%0d_dwe got %0d want %0d", i, o.dwe, e_dw); else n_pass++;
      n_tot++; if (o.inst !== t.rdata) $display("FAIL rnd%0d_inst got %h want %h", i, o.inst, t.rdata); else n_pass++;
      n_tot++; if (o.pre_req !== 0) $display("FAIL rnd%0d_stall got %0d want 0", i, o.pre_req); else n_pass++;
      n_tot++; if (o.pc_bad !== 0) $display("FAIL rnd%0d_pcstable got %0d want 0", i, o.pc_bad); else n_pass++;
      n_tot++; if (o.addr_bad !== 0) $display("FAIL rnd%0d_addr got %0d want 0", i, o.addr_bad); else n_pass++;
      if (h) do_reset();
      else m_pc = tg;
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jalr();
    test_mem();
    test_stall();
    test_illegal();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
